// File: rtl/d_ip_timer_mc.sv
`default_nettype none
// ============================================================================
// Module  : d_ip_timer_mc
// Brief   : Register-mapped timer with prescaler, external tick input,
//           NUM_CMP compare channels, match/overflow IRQs and toggle output.
// Revision: 1.0 - initial release
// ============================================================================
module d_ip_timer_mc #(
  parameter int CNT_W   = 16,
  parameter int NUM_CMP = 2
) (
  input  logic               clk,
  input  logic               rst_b,
  input  logic [5:0]         addr,
  input  logic               wr_en,
  input  logic               mod_en,
  input  logic [7:0]         wdata,
  output logic [7:0]         rdata,
  output logic               overflow_int,
  output logic [NUM_CMP-1:0] comp_match_int,
  output logic               timer_out,
  input  logic               timer_in
);

  localparam int c_STAT_W = NUM_CMP + 1;

  logic               r_en, r_src, r_mode, r_oneshot;
  logic [7:0]         r_psc;
  logic [7:0]         r_psc_cnt;
  logic [c_STAT_W-1:0] r_ien, r_stat;
  logic [CNT_W-1:0]   r_cnt;
  logic [7:0]         r_cnt_stage;
  logic [7:0]         r_cnt_shadow;
  logic [2:0]         r_sync;
  logic               r_timer_out;

  logic               w_bus_wr, w_bus_rd;
  logic               w_ctrl_wr, w_clr, w_cnt_commit, w_discard;
  logic               w_edge, w_psc_hit, w_tick, w_wrap;
  logic [c_STAT_W-1:0] w_set;
  logic [15:0]        w_cnt16, w_cnt_wr16;
  logic [7:0]         w_rd_data;
  logic [CNT_W-1:0]   w_cmp   [NUM_CMP];
  logic [15:0]        w_cmp16 [NUM_CMP];

  assign w_bus_wr     = mod_en & wr_en;
  assign w_bus_rd     = mod_en & ~wr_en;
  assign w_ctrl_wr    = w_bus_wr && (addr == 6'h00);
  assign w_clr        = w_ctrl_wr & wdata[7];
  assign w_cnt_commit = w_bus_wr && (addr == 6'h05);
  assign w_discard    = w_clr | w_cnt_commit;
  assign w_cnt16      = 16'(r_cnt);
  assign w_cnt_wr16   = {wdata, r_cnt_stage};

  // r_sync[0..1] synchronise, r_sync[2] remembers the previous level for edge detect
  assign w_edge    = r_sync[1] & ~r_sync[2];
  assign w_psc_hit = (r_psc_cnt == r_psc);
  assign w_tick    = r_en & (r_src ? w_edge : w_psc_hit);
  assign w_wrap    = r_mode ? (r_cnt == w_cmp[0]) : (r_cnt == {CNT_W{1'b1}});

  always_comb begin
    w_set = '0;
    if (w_tick && !w_discard) begin
      w_set[0] = w_wrap;
      for (int i = 0; i < NUM_CMP; i++) begin
        w_set[1+i] = (r_cnt == w_cmp[i]);
      end
    end
  end

  generate
    for (genvar i = 0; i < NUM_CMP; i++) begin : g_cmp
      logic [CNT_W-1:0] r_cmp;
      logic [7:0]       r_cmp_stage;
      logic [15:0]      w_cmp_wr16;

      assign w_cmp_wr16 = {wdata, r_cmp_stage};
      assign w_cmp[i]   = r_cmp;
      assign w_cmp16[i] = 16'(r_cmp);

      always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
          r_cmp       <= '0;
          r_cmp_stage <= '0;
        end else if (w_bus_wr) begin
          if (addr == 6'(8 + 2*i)) r_cmp_stage <= wdata;
          if (addr == 6'(9 + 2*i)) r_cmp       <= w_cmp_wr16[CNT_W-1:0];
        end
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      r_sync <= '0;
    end else if (w_clr) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[1:0], timer_in};
    end
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      r_psc_cnt <= '0;
    end else if (w_clr || !(r_en && !r_src) || w_psc_hit) begin
      r_psc_cnt <= '0;
    end else begin
      r_psc_cnt <= r_psc_cnt + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      r_en        <= 1'b0;
      r_src       <= 1'b0;
      r_mode      <= 1'b0;
      r_oneshot   <= 1'b0;
      r_psc       <= '0;
      r_ien       <= '0;
      r_stat      <= '0;
      r_cnt       <= '0;
      r_cnt_stage <= '0;
      r_timer_out <= 1'b0;
    end else begin
      if (w_ctrl_wr) {r_oneshot, r_mode, r_src, r_en} <= wdata[3:0];
      // One-shot expiry overrides a simultaneous software enable
      if (w_set[0] && r_oneshot) r_en <= 1'b0;

      if (w_bus_wr && addr == 6'h01) r_psc       <= wdata;
      if (w_bus_wr && addr == 6'h02) r_ien       <= wdata[c_STAT_W-1:0];
      if (w_bus_wr && addr == 6'h04) r_cnt_stage <= wdata;

      if (w_bus_wr && addr == 6'h03) r_stat <= (r_stat & ~wdata[c_STAT_W-1:0]) | w_set;
      else                           r_stat <= r_stat | w_set;

      if (w_clr)              r_cnt <= '0;
      else if (w_cnt_commit)  r_cnt <= w_cnt_wr16[CNT_W-1:0];
      else if (w_tick)        r_cnt <= w_wrap ? '0 : r_cnt + CNT_W'(1);

      if (w_set[1]) r_timer_out <= ~r_timer_out;
    end
  end

  always_comb begin
    w_rd_data = 8'h00;
    case (addr)
      6'h00:   w_rd_data = {4'b0000, r_oneshot, r_mode, r_src, r_en};
      6'h01:   w_rd_data = r_psc;
      6'h02:   w_rd_data = 8'(r_ien);
      6'h03:   w_rd_data = 8'(r_stat);
      6'h04:   w_rd_data = w_cnt16[7:0];
      6'h05:   w_rd_data = r_cnt_shadow;
      default: w_rd_data = 8'h00;
    endcase
    for (int i = 0; i < NUM_CMP; i++) begin
      if (addr == 6'(8 + 2*i)) w_rd_data = w_cmp16[i][7:0];
      if (addr == 6'(9 + 2*i)) w_rd_data = w_cmp16[i][15:8];
    end
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      rdata        <= '0;
      r_cnt_shadow <= '0;
    end else if (w_bus_rd) begin
      rdata <= w_rd_data;
      if (addr == 6'h04) r_cnt_shadow <= w_cnt16[15:8];
    end
  end

  assign overflow_int   = r_stat[0] & r_ien[0];
  assign comp_match_int = r_stat[NUM_CMP:1] & r_ien[NUM_CMP:1];
  assign timer_out      = r_timer_out;

endmodule
`default_nettype wire

// File: tb/tb_d_ip_timer_mc.sv
`default_nettype none
// ============================================================================
// Module  : tb_d_ip_timer_mc
// Brief   : Directed self-checking bench for d_ip_timer_mc.
// Revision: 1.0 - initial release
// ============================================================================
module tb_d_ip_timer_mc;

  localparam logic [5:0] c_CTRL = 6'h00, c_PSC = 6'h01, c_IEN = 6'h02, c_STAT = 6'h03;
  localparam logic [5:0] c_CNTL = 6'h04, c_CNTH = 6'h05;
  localparam logic [5:0] c_CMP0L = 6'h08, c_CMP0H = 6'h09, c_CMP1L = 6'h0A, c_CMP1H = 6'h0B;

  logic       clk = 1'b0;
  logic       rst_b = 1'b0;
  logic [5:0] addr = '0;
  logic       wr_en = 1'b0;
  logic       mod_en = 1'b0;
  logic [7:0] wdata = '0;
  logic [7:0] rdata;
  logic       overflow_int;
  logic [1:0] comp_match_int;
  logic       timer_out;
  logic       timer_in = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;
  logic [7:0] rd;

  d_ip_timer_mc #(.CNT_W(16), .NUM_CMP(2)) dut (
    .clk            (clk),
    .rst_b          (rst_b),
    .addr           (addr),
    .wr_en          (wr_en),
    .mod_en         (mod_en),
    .wdata          (wdata),
    .rdata          (rdata),
    .overflow_int   (overflow_int),
    .comp_match_int (comp_match_int),
    .timer_out      (timer_out),
    .timer_in       (timer_in)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic bus_wr(input logic [5:0] a, input logic [7:0] d);
    addr = a; wdata = d; wr_en = 1'b1; mod_en = 1'b1;
    @(posedge clk); #1;
    mod_en = 1'b0; wr_en = 1'b0;
  endtask

  task automatic bus_rd(input logic [5:0] a, output logic [7:0] d);
    addr = a; wr_en = 1'b0; mod_en = 1'b1;
    @(posedge clk); #1;
    d = rdata;
    mod_en = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset state
    wait_clk(3);
    check("rst_rdata", rdata, 0);
    check("rst_irq", {overflow_int, comp_match_int, timer_out}, 0);
    rst_b = 1'b1;
    wait_clk(1);
    bus_rd(c_CTRL, rd); check("rst_ctrl", rd, 8'h00);
    bus_rd(c_STAT, rd); check("rst_stat", rd, 8'h00);
    bus_rd(c_CNTL, rd); check("rst_cntl", rd, 8'h00);
    bus_wr(6'h06, 8'hAA);
    bus_rd(6'h06, rd); check("unmapped_06", rd, 8'h00);
    bus_wr(6'h0C, 8'h55);
    bus_rd(6'h0C, rd); check("unmapped_cmp2", rd, 8'h00);
    bus_wr(c_PSC, 8'h5A);
    bus_rd(c_PSC, rd); check("psc_rw", rd, 8'h5A);

    // 1: PSC=3 wrap overflow, started near the top to keep the run short
    bus_wr(c_PSC, 8'd3);
    bus_wr(c_CNTL, 8'hF0);
    bus_wr(c_CNTH, 8'hFF);
    bus_wr(c_IEN, 8'h01);
    bus_wr(c_CTRL, 8'h01);
    wait_clk(63); check("t1_ovf_before", overflow_int, 0);
    wait_clk(1);  check("t1_ovf_at_wrap", overflow_int, 1);
    bus_wr(c_CTRL, 8'h00);
    bus_rd(c_CNTL, rd); check("t1_cntl", rd, 8'h00);
    bus_rd(c_CNTH, rd); check("t1_cnth", rd, 8'h00);
    bus_rd(c_STAT, rd); check("t1_stat", rd, 8'h01);
    bus_wr(c_STAT, 8'h01);
    check("t1_w1c", overflow_int, 0);

    // 2: period-clear mode, CMP0=9
    bus_wr(c_PSC, 8'd0);
    bus_wr(c_CMP0L, 8'd9);
    bus_wr(c_CMP0H, 8'd0);
    bus_wr(c_STAT, 8'hFF);
    bus_wr(c_IEN, 8'h03);
    bus_wr(c_CTRL, 8'h05);
    wait_clk(9);
    check("t2_pre", {overflow_int, comp_match_int[0], timer_out}, 3'b000);
    wait_clk(1);
    check("t2_match", {overflow_int, comp_match_int[0], timer_out}, 3'b111);
    wait_clk(9);  check("t2_tout_hold", timer_out, 1);
    wait_clk(1);  check("t2_tout_toggle", timer_out, 0);
    bus_wr(c_CTRL, 8'h00);

    // 3: W1C colliding with a recurring CMP1 match
    bus_wr(c_CTRL, 8'h80);
    bus_wr(c_CMP1L, 8'd5);
    bus_wr(c_CMP1H, 8'd0);
    bus_wr(c_IEN, 8'h04);
    bus_wr(c_STAT, 8'hFF);
    bus_wr(c_CTRL, 8'h05);
    wait_clk(9);  check("t3_match", comp_match_int[1], 1);
    bus_wr(c_STAT, 8'h04);
    check("t3_w1c_clears", comp_match_int[1], 0);
    wait_clk(5);
    bus_wr(c_STAT, 8'h04);
    check("t3_set_wins", comp_match_int[1], 1);
    bus_wr(c_CTRL, 8'h00);

    // 4: external ticks; CMP1=0 flags the first tick
    bus_wr(c_CTRL, 8'h80);
    bus_wr(c_CMP1L, 8'd0);
    bus_wr(c_CMP1H, 8'd0);
    bus_wr(c_IEN, 8'h04);
    bus_wr(c_STAT, 8'hFF);
    bus_wr(c_CTRL, 8'h03);
    timer_in = 1'b1;
    wait_clk(2); check("t4_lag2", comp_match_int[1], 0);
    timer_in = 1'b0;
    wait_clk(1); check("t4_lag3", comp_match_int[1], 1);
    wait_clk(1);
    for (int p = 0; p < 6; p++) begin
      timer_in = 1'b1; wait_clk(2);
      timer_in = 1'b0; wait_clk(2);
    end
    wait_clk(2);
    bus_rd(c_CNTL, rd); check("t4_cntl", rd, 8'd7);
    bus_rd(c_CNTH, rd); check("t4_cnth", rd, 8'd0);
    bus_wr(c_CTRL, 8'h00);

    // 5: atomic CNT commit and hi-byte shadow across a carry
    bus_wr(c_CTRL, 8'h80);
    bus_wr(c_CNTL, 8'hFF);
    bus_wr(c_CTRL, 8'h01);
    bus_wr(c_CNTH, 8'h12);
    bus_rd(c_CNTL, rd); check("t5_lo", rd, 8'hFF);
    bus_rd(c_CNTH, rd); check("t5_hi_shadow", rd, 8'h12);
    bus_rd(c_CNTL, rd); check("t5_lo2", rd, 8'h01);
    bus_rd(c_CNTH, rd); check("t5_hi2", rd, 8'h13);
    bus_wr(c_CTRL, 8'h00);

    // 6: one-shot, then async reset mid-count
    bus_wr(c_CTRL, 8'h80);
    bus_wr(c_CMP0L, 8'd3);
    bus_wr(c_CMP0H, 8'd0);
    bus_wr(c_STAT, 8'hFF);
    bus_wr(c_IEN, 8'h01);
    bus_wr(c_CTRL, 8'h0D);
    wait_clk(3); check("t6_ovf_before", overflow_int, 0);
    wait_clk(1); check("t6_ovf", overflow_int, 1);
    wait_clk(2);
    bus_rd(c_CTRL, rd); check("t6_en_cleared", rd, 8'h0C);
    bus_rd(c_CNTL, rd); check("t6_cnt_held", rd, 8'h00);
    bus_rd(c_STAT, rd); check("t6_stat", rd, 8'h07);
    bus_wr(c_CTRL, 8'h05);
    wait_clk(2);
    check("t6_pre_rst", {rdata, overflow_int}, {8'h07, 1'b1});
    #2 rst_b = 1'b0;
    #1;
    check("t6_rst_rdata", rdata, 0);
    check("t6_rst_outs", {overflow_int, comp_match_int, timer_out}, 0);
    @(posedge clk); #1;
    rst_b = 1'b1;
    bus_rd(c_CTRL, rd);  check("t6_ctrl_after", rd, 8'h00);
    bus_rd(c_CNTL, rd);  check("t6_cnt_after", rd, 8'h00);
    bus_rd(c_CMP0L, rd); check("t6_cmp0_after", rd, 8'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
